// File: rtl/rsa_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsa_pkg
// Description : Shared types and sizing helpers for the RSA modexp engine.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package rsa_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        PRE_M = 3'd2,
        PRE_X = 3'd3,
        SQR   = 3'd4,
        MUL   = 3'd5,
        POST  = 3'd6,
        DONE  = 3'd7
    } rsa_state_t;

    // Multiplicand (B operand) selection for the Montgomery multiplier
    typedef enum logic [1:0] {
        OP_ONE  = 2'd0,
        OP_R2   = 2'd1,
        OP_MBAR = 2'd2,
        OP_XBAR = 2'd3
    } rsa_opsel_t;

    function automatic int cnt_width(input int width, input int exp_width);
        int span;
        span = (width + 2 > exp_width) ? width + 2 : exp_width;
        return $clog2(span + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rsa_mont_mult.sv
`default_nettype none
// ============================================================================
// Module      : rsa_mont_mult
// Description : Bit-serial Montgomery multiplier, r = a*b*2^-WIDTH mod p,
//               WIDTH+2 cycles per operation (load, iterate, subtract).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module rsa_mont_mult
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] p,
    output logic             done,
    output logic [WIDTH-1:0] r
);

    localparam int c_cnt_w = cnt_width(WIDTH, 1);
    localparam logic [c_cnt_w-1:0] c_last    = c_cnt_w'(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_p;
    logic [WIDTH+1:0]   r_s;
    logic [WIDTH+2:0]   w_sum_ab;
    logic [WIDTH+2:0]   w_sum;
    logic               w_ge;

    // q is picked from the parity of S + a_i*B so that adding q*P makes it even
    always_comb begin
        w_sum_ab = {1'b0, r_s} + (r_a[0] ? {3'b000, r_b} : '0);
        w_sum    = w_sum_ab + (w_sum_ab[0] ? {3'b000, r_p} : '0);
    end

    assign w_ge = (r_s >= {2'b00, r_p});
    assign r    = WIDTH'(w_ge ? (r_s - {2'b00, r_p}) : r_s);
    assign done = (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_p   <= '0;
            r_s   <= '0;
        end else if (en) begin
            if (start) begin
                r_s   <= '0;
                r_a   <= a;
                r_b   <= b;
                r_p   <= p;
                r_cnt <= c_cnt_one;
            end else if (r_cnt == c_last) begin
                r_cnt <= '0;
            end else if (r_cnt != '0) begin
                r_s   <= (WIDTH+2)'(w_sum >> 1);
                r_a   <= r_a >> 1;
                r_cnt <= r_cnt + c_cnt_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rsa_modexp_engine.sv
`default_nettype none
// ============================================================================
// Module      : rsa_modexp_engine
// Description : C = M^E mod P by Montgomery square-and-multiply, with operand
//               checking, constant-time mode and abort.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module rsa_modexp_engine
    import rsa_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int EXP_WIDTH = WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 const_time,
    input  logic [WIDTH-1:0]     p,
    input  logic [EXP_WIDTH-1:0] e,
    input  logic [WIDTH-1:0]     m,
    input  logic [WIDTH-1:0]     r2,
    output logic [WIDTH-1:0]     c,
    output logic                 busy,
    output logic                 eoc,
    output logic                 err,
    output logic                 aborted
);

    localparam int c_cnt_w = cnt_width(WIDTH, EXP_WIDTH);
    localparam logic [c_cnt_w-1:0]   c_idx_top = c_cnt_w'(EXP_WIDTH - 1);
    localparam logic [c_cnt_w-1:0]   c_idx_one = c_cnt_w'(1);
    localparam logic [WIDTH-1:0]     c_one     = WIDTH'(1);
    localparam logic [EXP_WIDTH-1:0] c_e_one   = EXP_WIDTH'(1);

    rsa_state_t           r_state, w_next;
    rsa_opsel_t           w_bsel;
    logic [WIDTH-1:0]     r_p, r_m, r_r2, r_mbar, r_xbar, r_c;
    logic [EXP_WIDTH-1:0] r_e;
    logic [c_cnt_w-1:0]   r_idx;
    logic                 r_ct, r_issue, r_err, r_aborted;
    logic [WIDTH-1:0]     w_a, w_b, w_prod;
    logic                 w_ok, w_ebit, w_last_bit, w_run, w_mstart, w_mdone;

    assign w_ok       = r_p[0] && (r_r2 < r_p);
    assign w_ebit     = |(r_e & (c_e_one << r_idx));
    assign w_last_bit = (r_idx == '0);
    assign w_run      = (r_state != IDLE) && (r_state != DONE);
    // First load overlaps CHECK so the op chain starts without a bubble
    assign w_mstart   = ((r_state == CHECK) && w_ok) || r_issue;

    always_comb begin
        w_a    = r_xbar;
        w_bsel = OP_ONE;
        case (r_state)
            CHECK, PRE_M: begin w_a = r_m;   w_bsel = OP_R2;   end
            PRE_X:        begin w_a = c_one; w_bsel = OP_R2;   end
            SQR:          w_bsel = OP_XBAR;
            MUL:          w_bsel = OP_MBAR;
            default:      ;
        endcase
        case (w_bsel)
            OP_R2:   w_b = r_r2;
            OP_MBAR: w_b = r_mbar;
            OP_XBAR: w_b = r_xbar;
            default: w_b = c_one;
        endcase
    end

    rsa_mont_mult #(.WIDTH(WIDTH)) u_mult (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (w_mstart),
        .a     (w_a),
        .b     (w_b),
        .p     (r_p),
        .done  (w_mdone),
        .r     (w_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     r_state <= IDLE;
        else if (en) r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (start && !stop) w_next = CHECK;
            CHECK: w_next = w_ok ? PRE_M : DONE;
            PRE_M: if (w_mdone) w_next = PRE_X;
            PRE_X: if (w_mdone) w_next = SQR;
            SQR:   if (w_mdone) w_next = (w_ebit || r_ct) ? MUL : (w_last_bit ? POST : SQR);
            MUL:   if (w_mdone) w_next = w_last_bit ? POST : SQR;
            POST:  if (w_mdone) w_next = DONE;
            default: w_next = IDLE;
        endcase
        if (w_run && stop) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p       <= '0;
            r_e       <= '0;
            r_m       <= '0;
            r_r2      <= '0;
            r_ct      <= 1'b0;
            r_mbar    <= '0;
            r_xbar    <= '0;
            r_idx     <= '0;
            r_c       <= '0;
            r_err     <= 1'b0;
            r_issue   <= 1'b0;
            r_aborted <= 1'b0;
        end else if (en) begin
            r_aborted <= w_run && stop;
            r_issue   <= w_mdone && ((w_next == PRE_X) || (w_next == SQR) ||
                                     (w_next == MUL) || (w_next == POST));
            if (r_state == IDLE && start && !stop) begin
                r_p   <= p;
                r_e   <= e;
                r_m   <= m;
                r_r2  <= r2;
                r_ct  <= const_time;
                r_err <= 1'b0;
            end
            if (r_state == CHECK && !w_ok && !stop) r_err <= 1'b1;
            if (w_mdone && !stop) begin
                case (r_state)
                    PRE_M: r_mbar <= w_prod;
                    PRE_X: begin
                        r_xbar <= w_prod;
                        r_idx  <= c_idx_top;
                    end
                    SQR: begin
                        r_xbar <= w_prod;
                        if (!(w_ebit || r_ct) && !w_last_bit) r_idx <= r_idx - c_idx_one;
                    end
                    MUL: begin
                        // Constant-time dummy multiply: result dropped when the bit is 0
                        if (w_ebit) r_xbar <= w_prod;
                        if (!w_last_bit) r_idx <= r_idx - c_idx_one;
                    end
                    POST:    r_c <= w_prod;
                    default: ;
                endcase
            end
        end
    end

    assign c       = r_c;
    assign busy    = w_run;
    assign eoc     = (r_state == DONE);
    assign err     = r_err;
    assign aborted = r_aborted;

endmodule
`default_nettype wire
